// File: rtl/tdpram_sc_v02.sv
// ----------------------------------------------------------------------------
// tdpram_sc_v02
// Single-clock, mixed-width true dual-port RAM with per-byte write enables.
//
// Both ports live in one clock domain, so a same-cycle access from both
// ports to the same physical bytes is resolved deterministically:
//   - write/write on a byte   : port A's byte is stored, port B's is dropped
//   - read/write on a byte    : the reader sees the old byte (READ_FIRST) or
//                               the byte being written (WRITE_FIRST)
// Collisions raise one-cycle pulses (coll_ww / coll_rw) and bump a
// saturating 16-bit debug counter (coll_cnt).
//
// Storage is organised as words of the wider port.  The narrower port uses
// its low log2(ratio) address bits to select a lane inside a wide word;
// lane 0 occupies wide-word bits [narrow-1:0].
//
// Every access (read, or write with its read-during-write result) produces a
// read-data word and a one-cycle rvld pulse, 1 cycle after the strobe, or 2
// cycles when the port's output register is enabled.  rdata holds its value
// between accesses.
//
// Optional feature (compile-time macro TDPRAM_SC_V02_INIT_CLR_EN):
//   defined   : after reset release a clear engine writes zero into one wide
//               word per cycle; init_done rises the cycle after the last word.
//               Asserting rst during the clear restarts it from word 0.
//   undefined : no clear engine; contents are undefined at power-up and kept
//               across rst; init_done rises on the first clock after rst.
// While init_done is low all port strobes are ignored.
//
// Parameters
//   PA_DW, PB_DW   : port data widths (multiples of BYTE_W, power-of-two ratio)
//   PA_AW          : port A word address width
//   PB_AW          : derived port B address width (same total capacity)
//   BYTE_W         : byte-lane width for write enables
//   RD_MODE        : "READ_FIRST" or "WRITE_FIRST"
//   PA_OREG/PB_OREG: "TRUE" adds an output register stage on that port
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   pa_en/pa_wr/pa_be/pa_addr/pa_wdata : port A access request
//   pa_rdata/pa_rvld            : port A read data and valid pulse
//   pb_*                        : same for port B at PB widths
//   coll_ww, coll_rw            : write-write / read-write collision pulses
//   coll_cnt                    : saturating collision count
//   init_done                   : array accessible
// ----------------------------------------------------------------------------
module tdpram_sc_v02 #(
    parameter int    PA_DW   = 32,
    parameter int    PB_DW   = 8,
    parameter int    PA_AW   = 8,
    parameter int    BYTE_W  = 8,
    parameter string RD_MODE = "READ_FIRST",
    parameter string PA_OREG = "TRUE",
    parameter string PB_OREG = "TRUE",
    localparam int   A_WIDE  = (PA_DW >= PB_DW) ? 1 : 0,
    localparam int   RATIO   = (A_WIDE != 0) ? (PA_DW / PB_DW) : (PB_DW / PA_DW),
    localparam int   LOG_R   = $clog2(RATIO),
    localparam int   PB_AW   = (A_WIDE != 0) ? (PA_AW + LOG_R) : (PA_AW - LOG_R),
    localparam int   PA_NB   = PA_DW / BYTE_W,
    localparam int   PB_NB   = PB_DW / BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pa_en,
    input  logic             pa_wr,
    input  logic [PA_NB-1:0] pa_be,
    input  logic [PA_AW-1:0] pa_addr,
    input  logic [PA_DW-1:0] pa_wdata,
    output logic [PA_DW-1:0] pa_rdata,
    output logic             pa_rvld,
    input  logic             pb_en,
    input  logic             pb_wr,
    input  logic [PB_NB-1:0] pb_be,
    input  logic [PB_AW-1:0] pb_addr,
    input  logic [PB_DW-1:0] pb_wdata,
    output logic [PB_DW-1:0] pb_rdata,
    output logic             pb_rvld,
    output logic             coll_ww,
    output logic             coll_rw,
    output logic [15:0]      coll_cnt,
    output logic             init_done
);

    localparam int WIDE_DW = (A_WIDE != 0) ? PA_DW : PB_DW;
    localparam int NB      = WIDE_DW / BYTE_W;
    localparam int MEM_AW  = (A_WIDE != 0) ? PA_AW : PB_AW;
    localparam int DEPTH   = 1 << MEM_AW;
    // Number of low address bits that pick a lane inside a wide word.
    localparam int A_SHIFT = (A_WIDE != 0) ? 0 : LOG_R;
    localparam int B_SHIFT = (A_WIDE != 0) ? LOG_R : 0;

    localparam bit WR_FIRST = (RD_MODE == "WRITE_FIRST");
    localparam bit A_OREG   = (PA_OREG == "TRUE");
    localparam bit B_OREG   = (PB_OREG == "TRUE");

    logic [WIDE_DW-1:0] mem [DEPTH];

    logic               a_act, b_act;
    logic [MEM_AW-1:0]  a_word, b_word;
    logic [NB-1:0]      a_amask, b_amask;
    logic [NB-1:0]      a_wmask, b_wmask;
    logic [WIDE_DW-1:0] a_wdata_w, b_wdata_w;
    logic [WIDE_DW-1:0] a_next, b_next;
    logic [WIDE_DW-1:0] a_src, b_src;
    logic [PA_DW-1:0]   a_rd_now;
    logic [PB_DW-1:0]   b_rd_now;
    logic               a_we, b_we;
    logic               same_word;
    logic               ww_now, rw_now;
    logic [16:0]        cnt_sum;

    logic [PA_DW-1:0]   pa_rd1;
    logic               pa_v1;
    logic [PB_DW-1:0]   pb_rd1;
    logic               pb_v1;

    // Byte-wise merge of up to two writes into an old word.  Port A's bytes
    // take priority, which is exactly the write-write resolution rule.
    function automatic logic [WIDE_DW-1:0] merge_word(
        input logic [WIDE_DW-1:0] old_w,
        input logic [NB-1:0]      am,
        input logic [WIDE_DW-1:0] ad,
        input logic [NB-1:0]      bm,
        input logic [WIDE_DW-1:0] bd
    );
        logic [WIDE_DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (am[i])
                r[i*BYTE_W +: BYTE_W] = ad[i*BYTE_W +: BYTE_W];
            else if (bm[i])
                r[i*BYTE_W +: BYTE_W] = bd[i*BYTE_W +: BYTE_W];
        end
        return r;
    endfunction

    // Map each port's request onto the wide-word array: word index, the bytes
    // its lane covers, the bytes it writes, and write data placed in its lane.
    always_comb begin
        int a_lane;
        int b_lane;
        a_act     = pa_en & init_done;
        b_act     = pb_en & init_done;
        a_lane    = int'(pa_addr) & ((1 << A_SHIFT) - 1);
        b_lane    = int'(pb_addr) & ((1 << B_SHIFT) - 1);
        a_word    = MEM_AW'(int'(pa_addr) >> A_SHIFT);
        b_word    = MEM_AW'(int'(pb_addr) >> B_SHIFT);
        a_amask   = '0;
        b_amask   = '0;
        a_wmask   = '0;
        b_wmask   = '0;
        if (a_act)
            a_amask = NB'({PA_NB{1'b1}}) << (a_lane * PA_NB);
        if (b_act)
            b_amask = NB'({PB_NB{1'b1}}) << (b_lane * PB_NB);
        if (a_act && pa_wr)
            a_wmask = NB'(pa_be) << (a_lane * PA_NB);
        if (b_act && pb_wr)
            b_wmask = NB'(pb_be) << (b_lane * PB_NB);
        a_wdata_w = WIDE_DW'(pa_wdata) << (a_lane * PA_DW);
        b_wdata_w = WIDE_DW'(pb_wdata) << (b_lane * PB_DW);
        same_word = (a_word == b_word);

        // Post-write value of each port's word, including the other port's
        // bytes when both target the same word.
        a_next = merge_word(mem[a_word], a_wmask, a_wdata_w,
                            same_word ? b_wmask : '0, b_wdata_w);
        b_next = merge_word(mem[b_word], same_word ? a_wmask : '0, a_wdata_w,
                            b_wmask, b_wdata_w);
        a_we   = |a_wmask;
        b_we   = |b_wmask;

        a_src    = WR_FIRST ? a_next : mem[a_word];
        b_src    = WR_FIRST ? b_next : mem[b_word];
        a_rd_now = PA_DW'(a_src >> (a_lane * PA_DW));
        b_rd_now = PB_DW'(b_src >> (b_lane * PB_DW));

        // A port's whole lane is read on every access, so a read-write
        // collision is a byte in one port's lane written only by the other.
        ww_now = same_word & (|(a_wmask & b_wmask));
        rw_now = same_word & ((|(a_amask & ~a_wmask & b_wmask)) |
                              (|(b_amask & ~b_wmask & a_wmask)));
        cnt_sum = {1'b0, coll_cnt} + 17'(ww_now) + 17'(rw_now);
    end

`ifdef TDPRAM_SC_V02_INIT_CLR_EN
    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

    clr_state_t        clr_state, clr_next;
    logic [MEM_AW-1:0] clr_addr;
    logic              clr_we;

    // Clear engine state and word pointer; rst restarts from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state <= CLR_IDLE;
            clr_addr  <= '0;
        end else begin
            clr_state <= clr_next;
            if (clr_we)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    // One idle cycle after reset, then one wide word per cycle until the
    // last word has been zeroed.
    always_comb begin
        clr_next = clr_state;
        clr_we   = 1'b0;
        case (clr_state)
            CLR_IDLE:  clr_next = CLR_CLEAR;
            CLR_CLEAR: begin
                clr_we = 1'b1;
                if (&clr_addr)
                    clr_next = CLR_DONE;
            end
            CLR_DONE:  clr_next = CLR_DONE;
            default:   clr_next = CLR_IDLE;
        endcase
    end

    assign init_done = (clr_state == CLR_DONE);
`else
    logic init_q;

    // Without a clear engine the array is usable one clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            init_q <= 1'b0;
        else
            init_q <= 1'b1;
    end

    assign init_done = init_q;
`endif

    // Array write.  Port A is applied last so that when both ports hit the
    // same word its merged value (which already includes B's bytes) lands.
    // The array itself is never reset.
    always_ff @(posedge clk) begin
`ifdef TDPRAM_SC_V02_INIT_CLR_EN
        if (clr_we)
            mem[clr_addr] <= '0;
`endif
        if (b_we)
            mem[b_word] <= b_next;
        if (a_we)
            mem[a_word] <= a_next;
    end

    // First read stage of each port; data only moves on an access so the
    // output holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_rd1 <= '0;
            pa_v1  <= 1'b0;
            pb_rd1 <= '0;
            pb_v1  <= 1'b0;
        end else begin
            pa_v1 <= a_act;
            pb_v1 <= b_act;
            if (a_act)
                pa_rd1 <= a_rd_now;
            if (b_act)
                pb_rd1 <= b_rd_now;
        end
    end

    // Optional second stage on port A.
    generate
        if (A_OREG) begin : g_pa_oreg
            logic [PA_DW-1:0] pa_rd2;
            logic             pa_v2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pa_rd2 <= '0;
                    pa_v2  <= 1'b0;
                end else begin
                    pa_v2 <= pa_v1;
                    if (pa_v1)
                        pa_rd2 <= pa_rd1;
                end
            end
            assign pa_rdata = pa_rd2;
            assign pa_rvld  = pa_v2;
        end else begin : g_pa_direct
            assign pa_rdata = pa_rd1;
            assign pa_rvld  = pa_v1;
        end
    endgenerate

    // Optional second stage on port B.
    generate
        if (B_OREG) begin : g_pb_oreg
            logic [PB_DW-1:0] pb_rd2;
            logic             pb_v2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pb_rd2 <= '0;
                    pb_v2  <= 1'b0;
                end else begin
                    pb_v2 <= pb_v1;
                    if (pb_v1)
                        pb_rd2 <= pb_rd1;
                end
            end
            assign pb_rdata = pb_rd2;
            assign pb_rvld  = pb_v2;
        end else begin : g_pb_direct
            assign pb_rdata = pb_rd1;
            assign pb_rvld  = pb_v1;
        end
    endgenerate

    // Collision pulses and the saturating counter update together, one
    // cycle after the colliding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_ww  <= 1'b0;
            coll_rw  <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll_ww  <= ww_now;
            coll_rw  <= rw_now;
            coll_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_tdpram_sc_v02.sv
// ----------------------------------------------------------------------------
// tb_tdpram_sc_v02
// Directed bench for tdpram_sc_v02 in its default shape (32-bit port A,
// 8-bit port B, both output registers on).  Two instances share the same
// stimulus: one READ_FIRST, one WRITE_FIRST, so collision read results for
// both modes are checked on identical traffic.
// ----------------------------------------------------------------------------
module tb_tdpram_sc_v02;

    localparam int PA_AW = 8;
    localparam int DEPTH = 1 << PA_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        pa_en, pa_wr;
    logic [3:0]  pa_be;
    logic [7:0]  pa_addr;
    logic [31:0] pa_wdata;
    logic        pb_en, pb_wr;
    logic [0:0]  pb_be;
    logic [9:0]  pb_addr;
    logic [7:0]  pb_wdata;

    logic [31:0] rf_pa_rdata, wf_pa_rdata;
    logic        rf_pa_rvld, wf_pa_rvld;
    logic [7:0]  rf_pb_rdata, wf_pb_rdata;
    logic        rf_pb_rvld, wf_pb_rvld;
    logic        rf_coll_ww, wf_coll_ww;
    logic        rf_coll_rw, wf_coll_rw;
    logic [15:0] rf_coll_cnt, wf_coll_cnt;
    logic        rf_init_done, wf_init_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdpram_sc_v02 #(
        .PA_DW(32), .PB_DW(8), .PA_AW(PA_AW), .BYTE_W(8),
        .RD_MODE("READ_FIRST"), .PA_OREG("TRUE"), .PB_OREG("TRUE")
    ) dut (
        .clk(clk), .rst(rst),
        .pa_en(pa_en), .pa_wr(pa_wr), .pa_be(pa_be), .pa_addr(pa_addr),
        .pa_wdata(pa_wdata), .pa_rdata(rf_pa_rdata), .pa_rvld(rf_pa_rvld),
        .pb_en(pb_en), .pb_wr(pb_wr), .pb_be(pb_be), .pb_addr(pb_addr),
        .pb_wdata(pb_wdata), .pb_rdata(rf_pb_rdata), .pb_rvld(rf_pb_rvld),
        .coll_ww(rf_coll_ww), .coll_rw(rf_coll_rw), .coll_cnt(rf_coll_cnt),
        .init_done(rf_init_done)
    );

    tdpram_sc_v02 #(
        .PA_DW(32), .PB_DW(8), .PA_AW(PA_AW), .BYTE_W(8),
        .RD_MODE("WRITE_FIRST"), .PA_OREG("TRUE"), .PB_OREG("TRUE")
    ) dut_wf (
        .clk(clk), .rst(rst),
        .pa_en(pa_en), .pa_wr(pa_wr), .pa_be(pa_be), .pa_addr(pa_addr),
        .pa_wdata(pa_wdata), .pa_rdata(wf_pa_rdata), .pa_rvld(wf_pa_rvld),
        .pb_en(pb_en), .pb_wr(pb_wr), .pb_be(pb_be), .pb_addr(pb_addr),
        .pb_wdata(pb_wdata), .pb_rdata(wf_pb_rdata), .pb_rvld(wf_pb_rvld),
        .coll_ww(wf_coll_ww), .coll_rw(wf_coll_rw), .coll_cnt(wf_coll_cnt),
        .init_done(wf_init_done)
    );

    // Advance one clock and land 1 time unit after the rising edge, which is
    // where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        pa_en = 1'b0; pa_wr = 1'b0; pa_be = '0; pa_addr = '0; pa_wdata = '0;
        pb_en = 1'b0; pb_wr = 1'b0; pb_be = '0; pb_addr = '0; pb_wdata = '0;
    endtask

    // Wait (bounded) for init_done and check how many edges it took.
    task automatic wait_init(input string tag, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (rf_init_done !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != exp_cycles || wf_init_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s init_cycles got %0d (wf init %b) expected %0d", tag, cyc, wf_init_done, exp_cycles);
        end
    endtask

    // Reset values, then time from reset release to init_done.
    task automatic test_reset();
        logic [60:0] obs;
        idle_ports();
        rst = 1'b1;
        tick();
        tick();
        obs = {rf_pa_rdata, rf_pb_rdata, rf_pa_rvld, rf_pb_rvld, rf_coll_ww,
               rf_coll_rw, rf_coll_cnt, rf_init_done};
        checks++;
        if (obs !== 61'd0) begin
            failures++;
            $display("[TB] FAIL reset_rf outputs got %h expected 0", obs);
        end
        obs = {wf_pa_rdata, wf_pb_rdata, wf_pa_rvld, wf_pb_rvld, wf_coll_ww,
               wf_coll_rw, wf_coll_cnt, wf_init_done};
        checks++;
        if (obs !== 61'd0) begin
            failures++;
            $display("[TB] FAIL reset_wf outputs got %h expected 0", obs);
        end
        rst = 1'b0;
`ifdef TDPRAM_SC_V02_INIT_CLR_EN
        wait_init("init_clear", DEPTH + 1);
        // Interrupt a fresh clear after a few words; it must start over.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (rf_init_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_restart init_done got %b expected 0", rf_init_done);
        end
        tick();
        rst = 1'b0;
        wait_init("init_restart", DEPTH + 1);
        pa_en = 1'b1; pa_addr = 8'd255;
        tick();
        idle_ports();
        tick();
        checks++;
        if (rf_pa_rdata !== 32'h0 || rf_pa_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cleared_read got %h vld %b expected 00000000 vld 1", rf_pa_rdata, rf_pa_rvld);
        end
`else
        wait_init("init_noclear", 1);
`endif
    endtask

    // A writes a full word, B reads its four lanes back-to-back.
    task automatic test_narrow_read();
        logic [7:0] exp_bytes [4];
        logic       exp_v;
        int         idx;
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        pa_en = 1'b1; pa_wr = 1'b1; pa_be = 4'hF; pa_addr = 8'd3; pa_wdata = 32'h44332211;
        tick();
        idle_ports();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                pb_en = 1'b1; pb_wr = 1'b0; pb_addr = 10'(12 + i);
            end else begin
                pb_en = 1'b0;
            end
            tick();
            exp_v = (i >= 1 && i <= 4);
            checks++;
            if (rf_pb_rvld !== exp_v) begin
                failures++;
                $display("[TB] FAIL narrow_rvld step %0d got %b expected %b", i, rf_pb_rvld, exp_v);
            end
            if (i >= 1) begin
                idx = (i - 1 > 3) ? 3 : i - 1;
                checks++;
                if (rf_pb_rdata !== exp_bytes[idx]) begin
                    failures++;
                    $display("[TB] FAIL narrow_rdata step %0d got %h expected %h", i, rf_pb_rdata, exp_bytes[idx]);
                end
            end
        end
    endtask

    // Partial write over a zeroed word, plus A's own read-during-write result.
    task automatic test_byte_enable();
        pa_en = 1'b1; pa_wr = 1'b1; pa_be = 4'hF; pa_addr = 8'd5; pa_wdata = 32'h0;
        tick();
        pa_be = 4'b0101; pa_wdata = 32'hAABBCCDD;
        tick();
        pa_wr = 1'b0; pa_be = 4'h0;
        tick();
        checks++;
        if (rf_pa_rdata !== 32'h00000000 || rf_pa_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rdw_read_first got %h vld %b expected 00000000 vld 1", rf_pa_rdata, rf_pa_rvld);
        end
        checks++;
        if (wf_pa_rdata !== 32'h00BB00DD) begin
            failures++;
            $display("[TB] FAIL rdw_write_first got %h expected 00bb00dd", wf_pa_rdata);
        end
        idle_ports();
        tick();
        checks++;
        if (rf_pa_rdata !== 32'h00BB00DD || rf_pa_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL byte_enable got %h vld %b expected 00bb00dd vld 1", rf_pa_rdata, rf_pa_rvld);
        end
    endtask

    // Both ports write byte 0 of word 7 in the same cycle.
    task automatic test_coll_ww();
        pa_en = 1'b1; pa_wr = 1'b1; pa_be = 4'b0001; pa_addr = 8'd7; pa_wdata = 32'h00000011;
        pb_en = 1'b1; pb_wr = 1'b1; pb_be = 1'b1; pb_addr = 10'd28; pb_wdata = 8'h22;
        tick();
        idle_ports();
        checks++;
        if (rf_coll_ww !== 1'b1 || rf_coll_rw !== 1'b0 || rf_coll_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL coll_ww ww=%b rw=%b cnt=%0d expected ww=1 rw=0 cnt=1", rf_coll_ww, rf_coll_rw, rf_coll_cnt);
        end
        pb_en = 1'b1; pb_addr = 10'd28;
        tick();
        idle_ports();
        checks++;
        if (rf_coll_ww !== 1'b0 || rf_coll_cnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL coll_ww_pulse ww=%b cnt=%0d expected ww=0 cnt=1", rf_coll_ww, rf_coll_cnt);
        end
        tick();
        checks++;
        if (rf_pb_rdata !== 8'h11 || wf_pb_rdata !== 8'h11) begin
            failures++;
            $display("[TB] FAIL ww_stored rf=%h wf=%h expected 11", rf_pb_rdata, wf_pb_rdata);
        end
    endtask

    // Read-write collisions in both directions on byte 1 of word 9.
    task automatic test_coll_rw();
        pa_en = 1'b1; pa_wr = 1'b1; pa_be = 4'hF; pa_addr = 8'd9; pa_wdata = 32'h00005500;
        tick();
        pa_be = 4'b0010; pa_wdata = 32'h00009900;
        pb_en = 1'b1; pb_wr = 1'b0; pb_addr = 10'd37;
        tick();
        idle_ports();
        checks++;
        if (rf_coll_rw !== 1'b1 || rf_coll_ww !== 1'b0 || rf_coll_cnt !== 16'd2 || wf_coll_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL coll_rw_b rw=%b ww=%b cnt=%0d wfcnt=%0d expected rw=1 ww=0 cnt=2", rf_coll_rw, rf_coll_ww, rf_coll_cnt, wf_coll_cnt);
        end
        tick();
        checks++;
        if (rf_pb_rdata !== 8'h55 || rf_pb_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rw_read_first_b got %h vld %b expected 55 vld 1", rf_pb_rdata, rf_pb_rvld);
        end
        checks++;
        if (wf_pb_rdata !== 8'h99 || wf_pb_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rw_write_first_b got %h vld %b expected 99 vld 1", wf_pb_rdata, wf_pb_rvld);
        end
        // Now B writes while A reads the whole word.
        pa_en = 1'b1; pa_wr = 1'b0; pa_addr = 8'd9;
        pb_en = 1'b1; pb_wr = 1'b1; pb_be = 1'b1; pb_addr = 10'd37; pb_wdata = 8'hEE;
        tick();
        idle_ports();
        checks++;
        if (wf_coll_rw !== 1'b1 || wf_coll_cnt !== 16'd3) begin
            failures++;
            $display("[TB] FAIL coll_rw_a rw=%b cnt=%0d expected rw=1 cnt=3", wf_coll_rw, wf_coll_cnt);
        end
        tick();
        checks++;
        if (rf_pa_rdata !== 32'h00009900) begin
            failures++;
            $display("[TB] FAIL rw_read_first_a got %h expected 00009900", rf_pa_rdata);
        end
        checks++;
        if (wf_pa_rdata !== 32'h0000EE00) begin
            failures++;
            $display("[TB] FAIL rw_write_first_a got %h expected 0000ee00", wf_pa_rdata);
        end
    endtask

    // Reset with a read in flight: nothing emerges, contents survive.
    task automatic test_reset_midop();
        logic [7:0] exp_d;
        pb_en = 1'b1; pb_wr = 1'b0; pb_addr = 10'd37;
        tick();
        idle_ports();
        rst = 1'b1;
        #1;
        checks++;
        if (rf_pb_rvld !== 1'b0 || rf_pb_rdata !== 8'h0 || rf_coll_cnt !== 16'd0 || rf_init_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_reset vld=%b rdata=%h cnt=%0d init=%b expected all 0", rf_pb_rvld, rf_pb_rdata, rf_coll_cnt, rf_init_done);
        end
        tick();
        rst = 1'b0;
`ifdef TDPRAM_SC_V02_INIT_CLR_EN
        wait_init("midop_init", DEPTH + 1);
        exp_d = 8'h00;
`else
        wait_init("midop_init", 1);
        exp_d = 8'hEE;
`endif
        tick();
        checks++;
        if (rf_pb_rvld !== 1'b0 || wf_pb_rvld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_discard rvld rf=%b wf=%b expected 0", rf_pb_rvld, wf_pb_rvld);
        end
        pb_en = 1'b1; pb_addr = 10'd37;
        tick();
        idle_ports();
        tick();
        checks++;
        if (rf_pb_rdata !== exp_d || rf_pb_rvld !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midop_contents got %h vld %b expected %h vld 1", rf_pb_rdata, rf_pb_rvld, exp_d);
        end
    endtask

    // One write-write collision per cycle until the counter pins at 0xFFFF.
    task automatic test_saturation();
        pa_en = 1'b1; pa_wr = 1'b1; pa_be = 4'b0001; pa_addr = 8'd20; pa_wdata = 32'h000000A5;
        pb_en = 1'b1; pb_wr = 1'b1; pb_be = 1'b1; pb_addr = 10'd80; pb_wdata = 8'h5A;
        repeat (65534) tick();
        checks++;
        if (rf_coll_cnt !== 16'hFFFE) begin
            failures++;
            $display("[TB] FAIL sat_pre got %h expected fffe", rf_coll_cnt);
        end
        tick();
        checks++;
        if (rf_coll_cnt !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL sat_reach got %h expected ffff", rf_coll_cnt);
        end
        tick();
        tick();
        checks++;
        if (rf_coll_cnt !== 16'hFFFF || rf_coll_ww !== 1'b1 || wf_coll_cnt !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL sat_hold cnt=%h wfcnt=%h ww=%b expected ffff ffff 1", rf_coll_cnt, wf_coll_cnt, rf_coll_ww);
        end
        idle_ports();
        tick();
    endtask

    initial begin
        test_reset();
        test_narrow_read();
        test_byte_enable();
        test_coll_ww();
        test_coll_rw();
        test_reset_midop();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdpram_sc_v02.md
# tdpram_sc_v02

Single-clock, mixed-width true dual-port RAM with per-byte write enables, deterministic same-address collision resolution, per-port read-valid pipeline and optional output registers. It succeeds the dual-clock byte-lane RAM for blocks that run both ports in one clock domain and need defined collision behaviour. It sits under packet buffers and descriptor tables where one port is the datapath and the other is a narrower or wider control/DMA port. Collisions are counted for debug.

## Interface
- PA_DW, 32: port A data width; multiple of BYTE_W.
- PB_DW, 8: port B data width; PA_DW/PB_DW or PB_DW/PA_DW is a power of two, at most 16.
- PA_AW, 8: port A address width.
- PB_AW, derived: PA_AW + log2(PA_DW/PB_DW), signed; total capacity is PA_DW*2**PA_AW bits.
- BYTE_W, 8: byte-lane width for write enables.
- RD_MODE, "READ_FIRST": "READ_FIRST" or "WRITE_FIRST" read-during-write result.
- PA_OREG, "TRUE": extra output register on port A.
- PB_OREG, "TRUE": extra output register on port B.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pa_en  in  1  port A access strobe.
- pa_wr  in  1  port A write (qualified by pa_en); read otherwise.
- pa_be  in  PA_DW/BYTE_W  port A byte enables.
- pa_addr  in  PA_AW  port A word address.
- pa_wdata  in  PA_DW  port A write data.
- pa_rdata  out  PA_DW  port A read data.
- pa_rvld  out  1  port A read data valid pulse.
- pb_en, pb_wr, pb_be, pb_addr, pb_wdata, pb_rdata, pb_rvld: same for port B with PB widths.
- coll_ww  out  1  write-write byte collision pulse.
- coll_rw  out  1  read-write collision pulse.
- coll_cnt  out  16  saturating collision count.
- init_done  out  1  array accessible.

## Operation
- Narrow port: low log2(ratio) address bits select lane inside wide word; lane 0 = wide-word bits [narrow-1:0].
- Write: bytes with be=1 updated at clk edge when en&wr; be=0 bytes untouched.
- Read: en&~wr returns full port-width word.
- Same-port read-during-write (en&wr): rdata is produced and rvld pulses; READ_FIRST returns old word, WRITE_FIRST returns merged new word.
- Collision: both ports enabled, addressing overlapping physical bytes same cycle.
- Write-write on a byte with both be=1: port A value stored, port B byte dropped; coll_ww pulses.
- Read-write: reader gets old byte (READ_FIRST) or writer's new byte (WRITE_FIRST) for collided bytes only; coll_rw pulses.
- Both ww and rw in one cycle: both pulses, coll_cnt +2 (saturates at 0xFFFF).
- During init (init_done=0): all en inputs ignored, no writes, rvld=0, no collisions counted.

## Timing
- Reset values: pa_rdata=0, pb_rdata=0, pa_rvld=0, pb_rvld=0, coll_ww=0, coll_rw=0, coll_cnt=0, init_done=0.
- Read latency: 1 cycle en-to-rdata with OREG "FALSE", 2 with "TRUE"; rvld aligned with rdata, one pulse per read.
- rdata holds last value between reads.
- Back-to-back reads every cycle sustain full throughput.
- coll_ww/coll_rw asserted 1 cycle after collision edge; coll_cnt updates same cycle as the pulse.
- Write visible to the other port's read issued next cycle.
- Reset mid-operation: in-flight reads discarded (rvld stays 0), array contents unchanged unless clear engine present.

## Configuration
- TDPRAM_SC_V02_INIT_CLR_EN defined: after rst release, clear FSM (IDLE→CLEAR→DONE) writes zero to one wide word per cycle, 2**max(PA_AW,PB_AW-wide) words; init_done rises the cycle after the last word; rst during CLEAR restarts from word 0.
- Undefined: no clear FSM; array contents undefined after power-up, preserved across rst; init_done=1 the first cycle after rst deasserts.

## Test plan
- PA_DW=32, PB_DW=8, OREG both TRUE: A writes 0x44332211 to addr 3, B reads addr 12..15 -> pb_rdata 0x11,0x22,0x33,0x44, each 2 cycles after pb_en with pb_rvld.
- Byte enables: A writes 0xAABBCCDD be=0b0101 over 0x00000000 -> A read returns 0x00BB00DD.
- Write-write: A writes 0x11 byte, B writes 0x22 same byte same cycle -> stored 0x11, coll_ww pulse next cycle, coll_cnt=1.
- Read-write, READ_FIRST vs WRITE_FIRST: old 0x55, A writes 0x99 while B reads -> B gets 0x55 / 0x99 respectively, coll_rw=1.
- Counter saturation: force 65536 collisions -> coll_cnt stays 0xFFFF.
- With TDPRAM_SC_V02_INIT_CLR_EN, PA_AW=4: init_done rises 17 cycles after rst release; any read returns 0; rst asserted at clear cycle 5 -> full 16-word clear restarts.
